// File: rtl/noc_tx_pkg.sv
// Shared types for the NoC packet transmitter: flit type codes, the FIFO entry layout and the
// transmit FSM state encoding.
package noc_tx_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_VC_W   = 2;

    // vc is only meaningful on the first word of a packet; later words carry zero.
    typedef struct packed {
        logic                    last;
        logic [ENTRY_VC_W-1:0]   vc;
        logic [ENTRY_DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    function automatic logic [1:0] flit_type(input logic first, input logic last);
        logic [1:0] t;
        case ({first, last})
            2'b10:   t = FLIT_TYPE_HEADER;
            2'b00:   t = FLIT_TYPE_PAYLOAD;
            2'b01:   t = FLIT_TYPE_LAST;
            default: t = FLIT_TYPE_SINGLE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/noc_tx_fifo.sv
// Synchronous FIFO holding packet words ahead of the flit output register.
// Head word is visible combinationally on rdata_o; push when full / pop when empty are ignored.
module noc_tx_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/noc_packet_tx.sv
// Store-and-forward NoC packet transmitter: buffers host words and emits typed flits on one VC.
// Optional statistics counters are built when NOC_PACKET_TX_STATS_EN is defined.
module noc_packet_tx
    import noc_tx_pkg::*;
#(
    parameter int NOC_FLIT_DATA_WIDTH = ENTRY_DATA_W,
    parameter int NOC_FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS           = 3,
    parameter int FIFO_DEPTH          = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_sys_n,
    input  logic [NOC_FLIT_DATA_WIDTH-1:0]                in_data,
    input  logic [$clog2(VCHANNELS)-1:0]                  in_vc,
    input  logic                                          in_last,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [NOC_FLIT_DATA_WIDTH+NOC_FLIT_TYPE_WIDTH-1:0] noc_out_flit,
    output logic [VCHANNELS-1:0]                          noc_out_valid,
    input  logic [VCHANNELS-1:0]                          noc_out_ready,
    output logic                                          busy,
    output logic [31:0]                                   stat_pkts,
    output logic [31:0]                                   stat_flits,
    output logic [31:0]                                   stat_stalls
);

    localparam int DW  = NOC_FLIT_DATA_WIDTH;
    localparam int TW  = NOC_FLIT_TYPE_WIDTH;
    localparam int VCW = $clog2(VCHANNELS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PW  = $clog2(FIFO_DEPTH + 2) + 1;

    fifo_entry_t       wr_entry, head;
    logic              push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, count_next;
    logic [VCW-1:0]    in_vc_eff;
    logic              hs;

    tx_state_t         state_q, state_d;
    logic [VCW-1:0]    vc_q, vc_d;
    logic              out_valid_q, out_valid_d;
    logic [TW+DW-1:0]  out_flit_q, out_flit_d;
    logic              out_last_q, out_last_d;
    logic              last_loaded_q, last_loaded_d;
    logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              in_first_q, in_first_d;

    always_comb begin
        in_vc_eff = (int'(in_vc) < VCHANNELS) ? in_vc : '0;
        push      = in_valid && in_ready_q;
        wr_entry  = '{last: in_last, vc: (in_first_q ? in_vc_eff : '0), data: in_data};
    end

    noc_tx_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_sys_n),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign hs = out_valid_q && noc_out_ready[vc_q];

    // A full FIFO also starts transmission so packets longer than the buffer cut through.
    always_comb begin
        state_d       = state_q;
        vc_d          = vc_q;
        out_valid_d   = out_valid_q;
        out_flit_d    = out_flit_q;
        out_last_d    = out_last_q;
        last_loaded_d = last_loaded_q;
        pop           = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (pkt_cnt_q != '0 || fifo_full) begin
                    state_d       = TX_SEND;
                    vc_d          = head.vc;
                    pop           = 1'b1;
                    out_valid_d   = 1'b1;
                    out_flit_d    = {TW'(flit_type(1'b1, head.last)), head.data};
                    out_last_d    = head.last;
                    last_loaded_d = head.last;
                end
            end
            TX_SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) state_d = TX_IDLE;
                end
                if ((!out_valid_q || hs) && !last_loaded_q && !fifo_empty) begin
                    pop           = 1'b1;
                    out_valid_d   = 1'b1;
                    out_flit_d    = {TW'(flit_type(1'b0, head.last)), head.data};
                    out_last_d    = head.last;
                    last_loaded_d = head.last;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        pkt_cnt_d  = pkt_cnt_q + PW'(push && in_last) - PW'(hs && out_last_q);
        in_first_d = push ? in_last : in_first_q;
        count_next = fifo_count + CW'(push) - CW'(pop);
        in_ready_d = (count_next < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q       <= TX_IDLE;
            vc_q          <= '0;
            out_valid_q   <= 1'b0;
            out_flit_q    <= '0;
            out_last_q    <= 1'b0;
            last_loaded_q <= 1'b0;
            pkt_cnt_q     <= '0;
            in_ready_q    <= 1'b0;
            in_first_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            vc_q          <= vc_d;
            out_valid_q   <= out_valid_d;
            out_flit_q    <= out_flit_d;
            out_last_q    <= out_last_d;
            last_loaded_q <= last_loaded_d;
            pkt_cnt_q     <= pkt_cnt_d;
            in_ready_q    <= in_ready_d;
            in_first_q    <= in_first_d;
        end
    end

    always_comb begin
        noc_out_valid       = '0;
        noc_out_valid[vc_q] = out_valid_q;
    end

    assign noc_out_flit = out_flit_q;
    assign in_ready     = in_ready_q;
    assign busy         = (state_q == TX_SEND);

`ifdef NOC_PACKET_TX_STATS_EN
    logic [31:0] pkts_q, pkts_d;
    logic [31:0] flits_q, flits_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        pkts_d   = pkts_q + 32'(hs && out_last_q);
        flits_d  = flits_q + 32'(hs);
        stalls_d = stalls_q + 32'(out_valid_q && !noc_out_ready[vc_q]);
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pkts_q   <= '0;
            flits_q  <= '0;
            stalls_q <= '0;
        end else begin
            pkts_q   <= pkts_d;
            flits_q  <= flits_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_pkts   = pkts_q;
    assign stat_flits  = flits_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_pkts   = '0;
    assign stat_flits  = '0;
    assign stat_stalls = '0;
`endif

endmodule
